imem_load_arbiter: RTL and testbench

IMEM_LOAD_ARBITER -- requirements
Module: imem_load_arbiter

---
 rtl/imem_load_arbiter.sv | 136 +++++++++++++
 tb/tb_imem_load_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_load_arbiter.sv
// Instruction-memory loader and port arbiter: packs a little-endian byte stream
// into 32-bit words and shares the single memory port with the fetch unit.
module imem_load_arbiter #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load_start,
  input  logic          load_end,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  input  logic          fetch_req,
  input  logic [AW-1:0] fetch_addr,
  output logic          fetch_gnt,
  output logic          fetch_stall,
  output logic          mem_we,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          load_done,
  output logic [AW:0]   word_count
);

  localparam int unsigned CW = AW + 1;
  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t        state;
  logic [1:0]    byte_idx;
  logic [AW-1:0] word_ptr;
  logic [31:0]   asm_word;
  logic [31:0]   asm_next;
  logic          run;
  logic          xfer;

  assign xfer = byte_valid && byte_ready;

  // Merge the incoming byte into the word under assembly; a new group clears upper bytes.
  always_comb begin
    asm_next = asm_word;
    case (byte_idx)
      2'd0:    asm_next = {24'h0, byte_data};
      2'd1:    asm_next[15:8]  = byte_data;
      2'd2:    asm_next[23:16] = byte_data;
      default: asm_next[31:24] = byte_data;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      run        <= 1'b0;
      byte_ready <= 1'b0;
      byte_idx   <= 2'd0;
      word_ptr   <= '0;
      word_count <= '0;
      asm_word   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      load_done  <= 1'b0;
    end else begin
      run    <= 1'b1;
      mem_we <= 1'b0;
      // A write strobe in this cycle retires one word.
      if (mem_we) begin
        word_ptr   <= word_ptr + AW'(1);
        word_count <= word_count + CW'(1);
      end
      case (state)
        IDLE, DONE: begin
          if (load_start) begin
            state      <= LOAD;
            byte_ready <= 1'b1;
            load_done  <= 1'b0;
            byte_idx   <= 2'd0;
            word_ptr   <= '0;
            word_count <= '0;
            asm_word   <= '0;
          end
        end
        LOAD: begin
          if (xfer) begin
            asm_word <= asm_next;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              mem_we    <= 1'b1;
              mem_wdata <= asm_next;
              if (word_ptr == LAST_WORD) byte_ready <= 1'b0;
            end
          end
          if (load_end) begin
            state      <= FLUSH;
            byte_ready <= 1'b0;
            // The flush write lands in the FLUSH cycle, while the loader still owns the port.
            if (xfer && byte_idx != 2'd3) begin
              mem_we    <= 1'b1;
              mem_wdata <= asm_next;
            end else if (!xfer && byte_idx != 2'd0) begin
              mem_we    <= 1'b1;
              mem_wdata <= asm_word;
            end
          end else if (mem_we && !byte_ready) begin
            state     <= DONE;
            load_done <= 1'b1;
          end
        end
        FLUSH: begin
          state     <= DONE;
          load_done <= 1'b1;
          byte_idx  <= 2'd0;
          asm_word  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Port ownership; fetch is held off until the first edge after reset.
  always_comb begin
    fetch_gnt   = 1'b0;
    mem_re      = 1'b0;
    fetch_stall = 1'b0;
    mem_addr    = word_ptr;
    if (state == LOAD || state == FLUSH) begin
      fetch_stall = 1'b1;
    end else if (run) begin
      mem_re    = fetch_req;
      fetch_gnt = fetch_req;
      mem_addr  = fetch_addr;
    end
  end

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Bench for imem_load_arbiter: arbitration vector table plus directed load
// sequences, with expected memory writes checked through a scoreboard queue.
module tb_imem_load_arbiter;

  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 256;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          load_start = 1'b0;
  logic          load_end = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic          byte_ready;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          fetch_gnt;
  logic          fetch_stall;
  logic          mem_we;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          load_done;
  logic [AW:0]   word_count;

  imem_load_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_start (load_start),
    .load_end   (load_end),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_gnt  (fetch_gnt),
    .fetch_stall(fetch_stall),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .load_done  (load_done),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    bit            load;
    logic          req;
    logic [AW-1:0] addr;
    logic          exp_gnt;
    logic          exp_re;
    logic          exp_stall;
    logic [AW-1:0] exp_addr;
  } vec_t;

  wr_t  sb[$];
  vec_t vecs[6];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   n_writes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock, then compare any memory write against the scoreboard.
  task automatic cycle();
    wr_t e;
    @(posedge clk);
    #1;
    if (mem_we) begin
      n_writes++;
      check("we_re_excl", 32'(mem_re), 32'd0);
      if (sb.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
      end else begin
        e = sb.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e.addr));
        check("wr_data", mem_wdata, e.data);
      end
    end
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    check("byte_ready", 32'(byte_ready), 32'd1);
    cycle();
  endtask

  task automatic start_load();
    byte_valid = 1'b0;
    load_start = 1'b1;
    cycle();
    load_start = 1'b0;
    check("start_ready", 32'(byte_ready), 32'd1);
    check("start_done", 32'(load_done), 32'd0);
    check("start_wc", 32'(word_count), 32'd0);
    check("start_stall", 32'(fetch_stall), 32'd1);
  endtask

  task automatic finish_load(input int exp_wc);
    byte_valid = 1'b0;
    load_end   = 1'b1;
    cycle();
    load_end = 1'b0;
    cycle();
    check("fin_done", 32'(load_done), 32'd1);
    check("fin_wc", 32'(word_count), 32'(exp_wc));
    check("fin_stall", 32'(fetch_stall), 32'd0);
  endtask

  function automatic logic [7:0] bval(input int k);
    return 8'((k * 7) + 3);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_we"}, 32'(mem_we), 32'd0);
    check({tag, "_re"}, 32'(mem_re), 32'd0);
    check({tag, "_gnt"}, 32'(fetch_gnt), 32'd0);
    check({tag, "_stall"}, 32'(fetch_stall), 32'd0);
    check({tag, "_done"}, 32'(load_done), 32'd0);
    check({tag, "_wc"}, 32'(word_count), 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    bit in_load;
    int base;
    vecs[0] = '{1'b0, 1'b1, 8'd5,   1'b1, 1'b1, 1'b0, 8'd5};
    vecs[1] = '{1'b0, 1'b0, 8'd5,   1'b0, 1'b0, 1'b0, 8'd5};
    vecs[2] = '{1'b0, 1'b1, 8'd255, 1'b1, 1'b1, 1'b0, 8'd255};
    vecs[3] = '{1'b1, 1'b1, 8'd5,   1'b0, 1'b0, 1'b1, 8'd0};
    vecs[4] = '{1'b1, 1'b0, 8'd9,   1'b0, 1'b0, 1'b1, 8'd0};
    vecs[5] = '{1'b1, 1'b1, 8'd255, 1'b0, 1'b0, 1'b1, 8'd0};

    // Reset with an active fetch request: everything must read zero.
    fetch_req  = 1'b1;
    fetch_addr = 8'd7;
    #3;
    check_reset_outputs("rst");
    @(negedge clk);
    reset_n = 1'b1;
    cycle();
    fetch_req = 1'b0;

    // Arbitration vectors in IDLE, then in LOAD.
    in_load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].load && !in_load) begin
        fetch_req = 1'b0;
        start_load();
        in_load = 1'b1;
      end
      fetch_req  = vecs[i].req;
      fetch_addr = vecs[i].addr;
      #1;
      check($sformatf("tbl%0d_gnt", i), 32'(fetch_gnt), 32'(vecs[i].exp_gnt));
      check($sformatf("tbl%0d_re", i), 32'(mem_re), 32'(vecs[i].exp_re));
      check($sformatf("tbl%0d_stall", i), 32'(fetch_stall), 32'(vecs[i].exp_stall));
      check($sformatf("tbl%0d_addr", i), 32'(mem_addr), 32'(vecs[i].exp_addr));
      check($sformatf("tbl%0d_we", i), 32'(mem_we), 32'd0);
      cycle();
    end
    fetch_req = 1'b0;
    finish_load(0);

    // Single instruction word.
    start_load();
    push_wr(8'd0, 32'h00500013);
    send_byte(8'h13);
    send_byte(8'h00);
    send_byte(8'h50);
    send_byte(8'h00);
    byte_valid = 1'b0;
    cycle();
    check("one_word_wc", 32'(word_count), 32'd1);
    finish_load(1);

    // Early end after six bytes: partial word padded with zeros.
    start_load();
    push_wr(8'd0, 32'h14131211);
    push_wr(8'd1, 32'h00001615);
    for (int k = 0; k < 6; k++) send_byte(8'(8'h11 + k));
    finish_load(2);

    // load_end in the same cycle as a byte: that byte is kept.
    start_load();
    push_wr(8'd0, 32'h24232221);
    push_wr(8'd1, 32'h00000025);
    for (int k = 0; k < 4; k++) send_byte(8'(8'h21 + k));
    byte_valid = 1'b1;
    byte_data  = 8'h25;
    load_end   = 1'b1;
    cycle();
    load_end   = 1'b0;
    byte_valid = 1'b0;
    check("same_cyc_stall", 32'(fetch_stall), 32'd1);
    cycle();
    check("same_cyc_done", 32'(load_done), 32'd1);
    check("same_cyc_wc", 32'(word_count), 32'd2);

    // load_start while loading must not restart the load.
    start_load();
    push_wr(8'd0, 32'hD4C3B2A1);
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    send_byte(8'hD4);
    byte_valid = 1'b0;
    load_start = 1'b1;
    cycle();
    load_start = 1'b0;
    check("restart_wc", 32'(word_count), 32'd1);
    check("restart_ready", 32'(byte_ready), 32'd1);
    push_wr(8'd1, 32'h44332211);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    finish_load(2);

    // Reset in the middle of word 3, then a fresh load from address 0.
    start_load();
    for (int k = 0; k < 12; k++) begin
      if (k % 4 == 3) push_wr(8'(k / 4), {bval(k), bval(k - 1), bval(k - 2), bval(k - 3)});
      send_byte(bval(k));
    end
    send_byte(8'hE0);
    send_byte(8'hE1);
    byte_valid = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 8'd3;
    reset_n    = 1'b0;
    #1;
    check_reset_outputs("midrst");
    cycle();
    cycle();
    @(negedge clk);
    reset_n   = 1'b1;
    fetch_req = 1'b0;
    cycle();
    cycle();
    start_load();
    push_wr(8'd0, 32'h04030201);
    for (int k = 1; k <= 4; k++) send_byte(8'(k));
    byte_valid = 1'b0;
    cycle();
    check("post_rst_wc", 32'(word_count), 32'd1);
    finish_load(1);

    // Full-depth continuous stream.
    base = n_writes;
    start_load();
    for (int k = 0; k < DEPTH * 4; k++) begin
      if (k % 4 == 3) push_wr(8'(k / 4), {bval(k), bval(k - 1), bval(k - 2), bval(k - 3)});
      send_byte(bval(k));
    end
    check("full_ready_low", 32'(byte_ready), 32'd0);
    byte_data = 8'hEE;
    cycle();
    byte_valid = 1'b0;
    check("full_done", 32'(load_done), 32'd1);
    check("full_wc", 32'(word_count), 32'(DEPTH));
    check("full_ready", 32'(byte_ready), 32'd0);
    cycle();
    cycle();
    check("full_writes", 32'(n_writes - base), 32'(DEPTH));

    // Fetch owns the port again once done.
    fetch_req  = 1'b1;
    fetch_addr = 8'h42;
    #1;
    check("done_re", 32'(mem_re), 32'd1);
    check("done_gnt", 32'(fetch_gnt), 32'd1);
    check("done_addr", 32'(mem_addr), 32'h42);
    cycle();
    fetch_req = 1'b0;

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
